// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-granular arbiter in front of async_transmitter. It sequences
// each byte through the start/busy handshake and inserts an idle gap between bytes.
module uart_tx_arbiter #(
  parameter int GAP_CYCLES   = 16,
  parameter int RISE_TIMEOUT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic [7:0]  data0,
  input  logic        last0,
  output logic        ack0,
  input  logic        req1,
  input  logic [7:0]  data1,
  input  logic        last1,
  output logic        ack1,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic [1:0]  grant,
  output logic [15:0] frames_sent,
  output logic        tx_error
);

  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int RW = (RISE_TIMEOUT > 1) ? $clog2(RISE_TIMEOUT) : 1;
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES);
  localparam logic [RW-1:0] RISE_LAST = RW'(RISE_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WAIT_RISE, WAIT_FALL, GAP, HOLD} state_t;

  state_t        state, state_d;
  logic [1:0]    grant_d;
  logic [7:0]    tx_data_d;
  logic          last_q, last_d;
  logic          rr, rr_d;
  logic [15:0]   frames_d;
  logic          err_d;
  logic [RW-1:0] rise_cnt, rise_d;
  logic [GW-1:0] gap_cnt, gap_d;
  logic          cap;
  logic          sel;
  logic          owner_req;

  // grant[1] identifies the owner while a frame is open
  assign owner_req = grant[1] ? req1 : req0;

  always_comb begin
    state_d   = state;
    grant_d   = grant;
    tx_data_d = tx_data;
    last_d    = last_q;
    rr_d      = rr;
    frames_d  = frames_sent;
    err_d     = tx_error;
    rise_d    = rise_cnt;
    gap_d     = gap_cnt;
    cap       = 1'b0;
    sel       = grant[1];
    case (state)
      IDLE: begin
        if (!tx_busy && (req0 || req1)) begin
          cap = 1'b1;
          sel = (req0 && req1) ? rr : req1;
        end
      end
      WAIT_RISE: begin
        if (tx_busy) begin
          state_d = WAIT_FALL;
        end else if (rise_cnt == RISE_LAST) begin
          // transmitter never acknowledged: flag it and treat the byte as done
          err_d   = 1'b1;
          state_d = GAP;
          gap_d   = GAP_LOAD;
        end else begin
          rise_d = rise_cnt + 1'b1;
        end
      end
      WAIT_FALL: begin
        if (!tx_busy) begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_cnt != '0) begin
          gap_d = gap_cnt - 1'b1;
        end else if (last_q) begin
          grant_d  = 2'b00;
          frames_d = frames_sent + 16'd1;
          rr_d     = ~grant[1];
          state_d  = IDLE;
        end else if (owner_req) begin
          cap = 1'b1;
        end else begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (owner_req) cap = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (cap) begin
      state_d   = WAIT_RISE;
      grant_d   = sel ? 2'b10 : 2'b01;
      tx_data_d = sel ? data1 : data0;
      last_d    = sel ? last1 : last0;
      rise_d    = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      grant       <= 2'b00;
      tx_data     <= 8'h00;
      last_q      <= 1'b0;
      rr          <= 1'b0;
      frames_sent <= 16'd0;
      tx_error    <= 1'b0;
      rise_cnt    <= '0;
      gap_cnt     <= '0;
      tx_start    <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
    end else begin
      state       <= state_d;
      grant       <= grant_d;
      tx_data     <= tx_data_d;
      last_q      <= last_d;
      rr          <= rr_d;
      frames_sent <= frames_d;
      tx_error    <= err_d;
      rise_cnt    <= rise_d;
      gap_cnt     <= gap_d;
      tx_start    <= cap;
      ack0        <= cap & ~sel;
      ack1        <= cap & sel;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a byte scoreboard checked on every tx_start,
// plus directed checks of reset, frame lock, gap latency, timeout and mid-frame reset.
module tb_uart_tx_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, last0, req1, last1;
  logic [7:0]  data0, data1;
  logic        ack0, ack1, tx_start, tx_busy, tx_error;
  logic [7:0]  tx_data;
  logic [1:0]  grant;
  logic [15:0] frames_sent;

  logic        z_reset, z_req0, z_last0, z_req1, z_last1, z_busy;
  logic [7:0]  z_data0, z_data1, z_tx_data;
  logic        z_ack0, z_ack1, z_tx_start, z_err;
  logic [1:0]  z_grant;
  logic [15:0] z_frames;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int bcnt = 0;
  bit model_en = 1'b1;
  logic [8:0] sb[$];
  int fall_cyc, last_lat;
  logic prev_busy;

  always #5 clock = ~clock;

  uart_tx_arbiter #(.GAP_CYCLES(4), .RISE_TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .data0(data0), .last0(last0), .ack0(ack0),
    .req1(req1), .data1(data1), .last1(last1), .ack1(ack1),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant(grant), .frames_sent(frames_sent), .tx_error(tx_error));

  uart_tx_arbiter #(.GAP_CYCLES(0), .RISE_TIMEOUT(8)) dut0 (
    .clock(clock), .reset(z_reset),
    .req0(z_req0), .data0(z_data0), .last0(z_last0), .ack0(z_ack0),
    .req1(z_req1), .data1(z_data1), .last1(z_last1), .ack1(z_ack1),
    .tx_start(z_tx_start), .tx_data(z_tx_data), .tx_busy(z_busy),
    .grant(z_grant), .frames_sent(z_frames), .tx_error(z_err));

  // Transmitter model: busy for 10 cycles starting the cycle after tx_start
  assign tx_busy = (bcnt != 0);
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (model_en && tx_start) bcnt <= 10;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every start must match the next expected {owner, byte}
  initial begin
    logic [8:0] e;
    prev_busy = 1'b0;
    fall_cyc  = 0;
    last_lat  = 0;
    forever begin
      @(negedge clock);
      if (reset && tx_start) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_start", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("sb_tx_data", 32'(tx_data), 32'(e[7:0]));
          chk("sb_grant", 32'(grant), e[8] ? 32'd2 : 32'd1);
          chk("sb_ack", 32'({ack1, ack0}), e[8] ? 32'd2 : 32'd1);
        end
        chk("start_while_busy", 32'(prev_busy), 32'd0);
        last_lat = cyc - fall_cyc;
      end
      if (prev_busy && !tx_busy) fall_cyc = cyc + 1;
      prev_busy = tx_busy;
    end
  end

  task automatic send(input bit r, input logic [7:0] d, input logic l);
    int n;
    if (r) begin req1 = 1'b1; data1 = d; last1 = l; end
    else   begin req0 = 1'b1; data0 = d; last0 = l; end
    n = 0;
    do begin @(negedge clock); n++; end while (!(r ? ack1 : ack0) && n < 1000);
    chk(r ? "ack1_wait" : "ack0_wait", 32'(n < 1000), 32'd1);
    @(posedge clock); #1;
    if (r) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic wait_frames(input logic [15:0] v);
    int n;
    n = 0;
    while (frames_sent !== v && n < 2000) begin @(negedge clock); n++; end
    chk("frames_sent", 32'(frames_sent), 32'(v));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_acks"}, 32'({ack1, ack0}), 32'd0);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_frames"}, 32'(frames_sent), 32'd0);
    chk({tag, "_tx_error"}, 32'(tx_error), 32'd0);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_reset_vals(tag);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    reset = 1'b0; z_reset = 1'b0;
    req0 = 0; data0 = 0; last0 = 0; req1 = 0; data1 = 0; last1 = 0;
    z_req0 = 0; z_data0 = 0; z_last0 = 0; z_req1 = 0; z_data1 = 0; z_last1 = 0; z_busy = 0;
    repeat (2) @(negedge clock);
    check_reset_vals("rst0");
    reset = 1'b1; z_reset = 1'b1;
    @(negedge clock);

    // Single byte
    sb.push_back({1'b0, 8'h5A});
    send(1'b0, 8'h5A, 1'b1);
    chk("single_grant_open", 32'(grant), 32'd1);
    wait_frames(16'd1);
    chk("single_grant_closed", 32'(grant), 32'd0);

    // Simultaneous requests from a fresh reset: 0, then 1, then 0 alone, then both again with rr=1
    pulse_reset("rst1");
    sb.push_back({1'b0, 8'hA0});
    sb.push_back({1'b1, 8'hB1});
    fork
      send(1'b0, 8'hA0, 1'b1);
      send(1'b1, 8'hB1, 1'b1);
    join
    wait_frames(16'd2);
    sb.push_back({1'b0, 8'hA2});
    send(1'b0, 8'hA2, 1'b1);
    wait_frames(16'd3);
    sb.push_back({1'b1, 8'hD1});
    sb.push_back({1'b0, 8'hD0});
    fork
      send(1'b0, 8'hD0, 1'b1);
      send(1'b1, 8'hD1, 1'b1);
    join
    wait_frames(16'd5);

    // Frame lock: requester 1 pauses mid-frame while requester 0 waits
    sb.push_back({1'b1, 8'h01});
    sb.push_back({1'b1, 8'h02});
    sb.push_back({1'b1, 8'h03});
    sb.push_back({1'b0, 8'hE0});
    fork
      begin
        send(1'b1, 8'h01, 1'b0);
        send(1'b1, 8'h02, 1'b0);
        repeat (20) @(posedge clock);
        @(negedge clock);
        chk("lock_grant", 32'(grant), 32'd2);
        chk("lock_no_ack0", 32'(ack0), 32'd0);
        send(1'b1, 8'h03, 1'b1);
      end
      begin
        n = 0;
        while (grant != 2'b10 && n < 100) begin @(negedge clock); n++; end
        send(1'b0, 8'hE0, 1'b1);
      end
    join
    wait_frames(16'd7);

    // Gap timing inside a frame, GAP_CYCLES=4
    sb.push_back({1'b0, 8'h31});
    sb.push_back({1'b0, 8'h32});
    send(1'b0, 8'h31, 1'b0);
    send(1'b0, 8'h32, 1'b1);
    chk("gap4_latency", 32'(last_lat), 32'd5);
    wait_frames(16'd8);

    // Timeout: transmitter never goes busy
    model_en = 1'b0;
    sb.push_back({1'b1, 8'h77});
    req1 = 1'b1; data1 = 8'h77; last1 = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!ack1 && n < 100);
    chk("timeout_ack1_wait", 32'(n < 100), 32'd1);
    @(posedge clock); #1;
    req1 = 1'b0;
    repeat (6) @(posedge clock);
    @(negedge clock);
    chk("timeout_err_before", 32'(tx_error), 32'd0);
    @(negedge clock);
    chk("timeout_err_set", 32'(tx_error), 32'd1);
    wait_frames(16'd9);
    chk("timeout_err_sticky", 32'(tx_error), 32'd1);
    model_en = 1'b1;
    sb.push_back({1'b0, 8'h44});
    send(1'b0, 8'h44, 1'b1);
    wait_frames(16'd10);
    chk("timeout_err_sticky2", 32'(tx_error), 32'd1);

    // Reset during WAIT_FALL of byte 2 of 3
    pulse_reset("rst2");
    sb.push_back({1'b0, 8'hAA});
    sb.push_back({1'b0, 8'hBB});
    send(1'b0, 8'hAA, 1'b0);
    send(1'b0, 8'hBB, 1'b0);
    n = 0;
    while (!tx_busy && n < 50) begin @(negedge clock); n++; end
    @(negedge clock);
    pulse_reset("rst_mid");
    chk("mid_busy_still_high", 32'(tx_busy), 32'd1);
    sb.push_back({1'b1, 8'h5F});
    send(1'b1, 8'h5F, 1'b1);
    wait_frames(16'd1);

    // Gap timing with GAP_CYCLES=0
    @(negedge clock);
    z_req0 = 1'b1; z_data0 = 8'h11; z_last0 = 1'b0;
    n = 0;
    do begin @(negedge clock); n++; end while (!z_tx_start && n < 50);
    chk("gap0_first_data", 32'(z_tx_data), 32'h11);
    @(posedge clock); #1;
    z_data0 = 8'h22; z_last0 = 1'b1; z_busy = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    z_busy = 1'b0;
    k = cyc;
    n = 0;
    do begin @(negedge clock); n++; end while (!z_tx_start && n < 50);
    chk("gap0_latency", 32'(cyc - (k + 1)), 32'd1);
    chk("gap0_second_data", 32'(z_tx_data), 32'h22);
    chk("gap0_ack0", 32'(z_ack0), 32'd1);
    @(posedge clock); #1;
    z_req0 = 1'b0;
    n = 0;
    while (z_frames !== 16'd1 && n < 100) begin @(negedge clock); n++; end
    chk("gap0_frames", 32'(z_frames), 32'd1);

    repeat (5) @(negedge clock);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
